dmem_sram_responder: RTL and testbench
======================================

# dmem_sram_responder

Data-side sram-like responder that sits opposite the CPU datapath's memory-stage port (req/wr/size/addr/wdata → addr_ok/data_ok/rdata). It owns a word-organised data RAM, accepts up to QDEPTH in-order requests, and returns one data_ok pulse per accepted request after a fixed latency. It is used as the dmem behind the core in simulation and as the on-chip scratch RAM in small builds.

## Interface
- ADDR_W, 10: word-address width; RAM holds 2**ADDR_W 32-bit words.
- LATENCY, 2: cycles from acceptance to data_ok; legal range 1..15.
- QDEPTH, 4: maximum outstanding accepted-but-unanswered requests; legal range 1..8.

- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset; synchronous and active-high.
- data_req  in  1  request valid.
- data_wr  in  1  1 = write, 0 = read.
- data_size  in  2  0 byte, 1 half, 2 word, 3 reserved (treated as word).
- data_addr  in  32  byte address.
- data_wdata  in  32  write data, already lane-positioned by the initiator.
- data_addr_ok  out  1  request accepted this cycle when data_req & data_addr_ok.
- data_data_ok  out  1  one-cycle response pulse, in acceptance order.
- data_rdata  out  32  full read word; valid only while data_data_ok.

## Operation
- Word index = data_addr[ADDR_W+1:2]; higher address bits ignored (aliasing wrap).
- Byte enables: size 0 → 4'b0001 << addr[1:0]; size 1 → addr[1] ? 4'b1100 : 4'b0011 (addr[0] ignored); size 2/3 → 4'b1111. No alignment checks; the core raises address exceptions itself.
- Acceptance (req & addr_ok at edge): a write updates the enabled byte lanes of RAM at that edge; a read samples the full word at that edge (post any earlier write, so RAW through the queue is correct). An entry {is_write, rdata, age} is pushed into the response FIFO.
- Each entry's age increments every cycle; the head entry is answered in the cycle in which its age equals LATENCY. At most one response per cycle; ordering strictly FIFO.
- Response: data_data_ok = 1 for exactly one cycle; data_rdata = sampled word for reads, 32'h0 for writes. Entry popped at the end of that cycle.
- data_addr_ok = ~rst & (count < QDEPTH), combinational from registered count only (no dependence on data_req, no credit from a same-cycle pop).
- Simultaneous push and pop: count unchanged; both take effect.
- data_req with data_addr_ok = 0: nothing happens; initiator must hold request stable until accepted.
- RAM contents are not reset.

## Timing
- Reset: count = 0, FIFO empty, data_addr_ok = 0, data_data_ok = 0, data_rdata = 0. In-flight responses discarded and never answered; writes already accepted stay in RAM.
- First cycle after rst deasserts: data_addr_ok = 1.
- Accept at edge n → data_data_ok high in cycle n+LATENCY (registered output), i.e. LATENCY=1 answers in the cycle right after acceptance.
- Throughput: one request per cycle sustained iff QDEPTH > LATENCY; with QDEPTH ≤ LATENCY, addr_ok drops while full and resumes the cycle after a pop.
- data_data_ok is never asserted while count = 0, never twice for one entry.

## Test plan
- Word write then read: write addr 0x00000010 wdata 0xDEADBEEF size 2, then read same addr → second data_ok carries 0xDEADBEEF, first data_ok carries 0x00000000; each data_ok exactly LATENCY cycles after its accept.
- Byte/half lanes: word 0x11223344 at 0x20, sb wdata 0xAAAAAAAA at 0x21, sh wdata 0xBBBBBBBB at 0x22, read 0x20 → 0xBBBBAA44.
- Back-to-back with LATENCY=2, QDEPTH=4: 8 consecutive reads of distinct preloaded words → addr_ok never drops, 8 data_ok pulses on consecutive cycles, rdata in issue order.
- Backpressure with LATENCY=4, QDEPTH=2: hold data_req high → addr_ok pattern 1,1,0,0,0,1…; accepted count equals data_ok count, no lost/duplicated responses.
- Reset mid-flight: accept write 0x55 to 0x40 and two reads, assert rst one cycle → no data_ok afterwards for those; after reset read 0x40 returns 0x00000055.
- Aliasing: with ADDR_W=10 write 0xCAFEF00D to 0x00001000, read 0x00000000 → 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_sram_responder.sv
// Data-side sram-like responder: word-organised RAM behind a req/addr_ok, data_ok handshake.
// Accepted requests queue in order and are answered exactly LATENCY cycles after acceptance.
module dmem_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int AGE_W = 5;

  typedef struct packed {
    logic             is_write;
    logic [31:0]      data;
    logic [AGE_W-1:0] age;
  } entry_t;

  logic [31:0]       ram [2**ADDR_W];
  entry_t            fifo [QDEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [CNT_W-1:0]  count;
  logic              data_ok_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        be;
  logic [31:0]       rd_word;
  logic [CNT_W-1:0]  remain;
  entry_t            cand;
  logic              cand_valid;
  logic              resp_next;
  logic              unused_addr_bits;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign data_addr_ok     = ~rst & (count < CNT_W'(QDEPTH));
  assign accept           = data_req & data_addr_ok;
  assign pop              = data_ok_q;
  assign word_idx         = data_addr[ADDR_W+1:2];
  assign rd_word          = ram[word_idx];
  assign remain           = count - CNT_W'(pop);
  assign unused_addr_bits = ^data_addr[31:ADDR_W+2];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    be = 4'b1111;
    case (data_size)
      2'd0:    be = 4'b0001 << data_addr[1:0];
      2'd1:    be = data_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Entry that will sit at the head next cycle, with the age it will have then.
  // An empty queue lets a same-edge push become head, which is how LATENCY=1 works.
  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    if (remain != '0) begin
      cand       = fifo[pop ? next_ptr(head) : head];
      cand.age   = cand.age + AGE_W'(1);
      cand_valid = 1'b1;
    end else if (accept) begin
      cand       = '{is_write: data_wr, data: rd_word, age: AGE_W'(1)};
      cand_valid = 1'b1;
    end
  end

  assign resp_next = cand_valid && (cand.age == AGE_W'(LATENCY));

  // NOTE: RAM contents are deliberately never reset, so this block has no reset branch.
  always_ff @(posedge clk) begin
    if (accept && data_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) ram[word_idx][8*b +: 8] <= data_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        fifo[i].age <= fifo[i].age + AGE_W'(1);
      end
      if (accept) begin
        fifo[tail] <= '{is_write: data_wr, data: rd_word, age: AGE_W'(1)};
        tail       <= next_ptr(tail);
      end
      if (pop) head <= next_ptr(head);
      unique case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      data_ok_q <= resp_next;
      rdata_q   <= (resp_next && !cand.is_write) ? cand.data : 32'h0;
    end
  end

  assign data_data_ok = data_ok_q;
  assign data_rdata   = rdata_q;

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Bench for dmem_sram_responder: two instances (LATENCY 2/QDEPTH 4 and LATENCY 4/QDEPTH 2)
// checked every cycle against a queue-of-due-times model plus a few literal expectations.
module tb_dmem_sram_responder;

  localparam int LAT [2] = '{2, 4};
  localparam int QD  [2] = '{4, 2};

  typedef struct packed {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        wr    [2];
  logic [1:0]  size  [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        addr_ok [2];
  logic        data_ok [2];
  logic [31:0] rdata   [2];

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  exp_t        exp_q [2][$];
  logic [31:0] mmem  [2][1024];
  logic [31:0] last_rdata [2];
  int          acc_n [2];
  int          dok_n [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_sram_responder #(.ADDR_W(10), .LATENCY(2), .QDEPTH(4)) u_dut0 (
    .clk(clk), .rst(rst), .data_req(req[0]), .data_wr(wr[0]), .data_size(size[0]),
    .data_addr(addr[0]), .data_wdata(wdata[0]), .data_addr_ok(addr_ok[0]),
    .data_data_ok(data_ok[0]), .data_rdata(rdata[0]));

  dmem_sram_responder #(.ADDR_W(10), .LATENCY(4), .QDEPTH(2)) u_dut1 (
    .clk(clk), .rst(rst), .data_req(req[1]), .data_wr(wr[1]), .data_size(size[1]),
    .data_addr(addr[1]), .data_wdata(wdata[1]), .data_addr_ok(addr_ok[1]),
    .data_data_ok(data_ok[1]), .data_rdata(rdata[1]));

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, i, cyc, act, exp);
    end
  endtask

  // Reference model: a request accepted at the edge after this sample is due LATENCY samples later.
  always @(negedge clk) begin : mon
    logic [3:0]  be;
    logic [9:0]  widx;
    logic [31:0] w;
    if (cyc > 0) begin
      for (int i = 0; i < 2; i++) begin
        check("addr_ok", i, 32'(addr_ok[i]), 32'(!rst && exp_q[i].size() < QD[i]));
        while (exp_q[i].size() > 0 && exp_q[i][0].due < cyc) begin
          check("missed_resp", i, 32'(exp_q[i][0].due), 32'(cyc));
          void'(exp_q[i].pop_front());
        end
        if (exp_q[i].size() > 0 && exp_q[i][0].due == cyc) begin
          check("data_ok", i, 32'(data_ok[i]), 32'd1);
          check("rdata", i, rdata[i], exp_q[i][0].data);
          last_rdata[i] = rdata[i];
          void'(exp_q[i].pop_front());
        end else begin
          check("data_ok", i, 32'(data_ok[i]), 32'd0);
        end
        if (data_ok[i]) dok_n[i]++;
        if (rst) begin
          exp_q[i].delete();
          acc_n[i] = 0;
          dok_n[i] = 0;
        end else if (req[i] && addr_ok[i]) begin
          acc_n[i]++;
          widx = addr[i][11:2];
          case (size[i])
            2'd0:    be = 4'b0001 << addr[i][1:0];
            2'd1:    be = addr[i][1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
          endcase
          if (wr[i]) begin
            w = mmem[i][widx];
            for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[i][8*b +: 8];
            mmem[i][widx] = w;
            exp_q[i].push_back('{due: cyc + LAT[i], data: 32'h0});
          end else begin
            exp_q[i].push_back('{due: cyc + LAT[i], data: mmem[i][widx]});
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic issue(input int i, input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    bit done = 0;
    req[i] = 1'b1; wr[i] = w; size[i] = s; addr[i] = a; wdata[i] = d;
    for (int t = 0; t < 64 && !done; t++) begin
      @(negedge clk);
      if (addr_ok[i]) done = 1;
      @(posedge clk); #1;
    end
    if (!done) check("accept_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic idle(input int i);
    req[i] = 1'b0;
  endtask

  task automatic drain(input int i);
    for (int t = 0; t < 64 && exp_q[i].size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check("drain", i, 32'(exp_q[i].size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic rand_run(input int i, input int n);
    logic [31:0] a;
    for (int k = 0; k < 64; k++)
      issue(i, 1'b1, 2'd2, 32'h0000_0C00 | 32'(k << 2), $urandom);
    for (int k = 0; k < n; k++) begin
      a = ($urandom & 32'hFFFF_F003) | 32'h0000_0C00 | 32'($urandom_range(0, 63) << 2);
      issue(i, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        idle(i);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    idle(i);
    drain(i);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [5:0] pat;
    int         c0;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; wr[i] = 1'b0; size[i] = 2'd0; addr[i] = '0; wdata[i] = '0;
      last_rdata[i] = '0; acc_n[i] = 0; dok_n[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_addr_ok", 0, 32'(addr_ok[0]), 32'd1);
    check("post_rst_rdata", 0, rdata[0], 32'h0);
    check("post_rst_data_ok", 1, 32'(data_ok[1]), 32'd0);
    @(posedge clk); #1;

    // Word write then read
    issue(0, 1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(0, 1'b0, 2'd2, 32'h0000_0010, 32'h0);
    idle(0);
    drain(0);
    check("word_rw", 0, last_rdata[0], 32'hDEAD_BEEF);

    // Byte and half lanes
    issue(0, 1'b1, 2'd2, 32'h0000_0020, 32'h1122_3344);
    issue(0, 1'b1, 2'd0, 32'h0000_0021, 32'hAAAA_AAAA);
    issue(0, 1'b1, 2'd1, 32'h0000_0022, 32'hBBBB_BBBB);
    issue(0, 1'b0, 2'd2, 32'h0000_0020, 32'h0);
    idle(0);
    drain(0);
    check("lanes_model", 0, mmem[0][8], 32'hBBBB_AA44);
    check("lanes_dut", 0, last_rdata[0], 32'hBBBB_AA44);

    // Back-to-back reads: eight accepts in eight cycles
    for (int k = 0; k < 8; k++)
      issue(0, 1'b1, 2'd2, 32'h0000_0100 + 32'(k * 4), 32'h1000_0000 + 32'(k * 32'h111));
    idle(0);
    drain(0);
    c0 = cyc;
    for (int k = 0; k < 8; k++)
      issue(0, 1'b0, 2'd2, 32'h0000_0100 + 32'(k * 4), 32'h0);
    check("b2b_cycles", 0, 32'(cyc - c0), 32'd8);
    idle(0);
    drain(0);
    check("b2b_last", 0, last_rdata[0], 32'h1000_0777);

    // Backpressure on the LATENCY=4 / QDEPTH=2 instance
    issue(1, 1'b1, 2'd2, 32'h0000_0080, 32'h0BAD_F00D);
    idle(1);
    drain(1);
    req[1] = 1'b1; wr[1] = 1'b0; size[1] = 2'd2; addr[1] = 32'h0000_0080;
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pat = {pat[4:0], addr_ok[1]};
      @(posedge clk); #1;
    end
    idle(1);
    drain(1);
    check("bp_pattern", 1, 32'(pat), 32'(6'b110001));
    check("bp_acc_vs_resp", 1, 32'(dok_n[1]), 32'(acc_n[1]));
    check("bp_rdata", 1, last_rdata[1], 32'h0BAD_F00D);

    // Reset with requests in flight
    issue(0, 1'b1, 2'd2, 32'h0000_0040, 32'h0000_0055);
    issue(0, 1'b0, 2'd2, 32'h0000_0040, 32'h0);
    issue(0, 1'b0, 2'd2, 32'h0000_0040, 32'h0);
    rst = 1'b1;
    idle(0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    check("rst_no_resp", 0, 32'(dok_n[0]), 32'd0);
    issue(0, 1'b0, 2'd2, 32'h0000_0040, 32'h0);
    idle(0);
    drain(0);
    check("rst_ram_kept", 0, last_rdata[0], 32'h0000_0055);

    // Address aliasing above the word index
    issue(1, 1'b1, 2'd2, 32'h0000_1000, 32'hCAFE_F00D);
    issue(1, 1'b0, 2'd2, 32'h0000_0000, 32'h0);
    idle(1);
    drain(1);
    check("alias", 1, last_rdata[1], 32'hCAFE_F00D);

    // Randomized traffic on both instances in parallel
    fork
      rand_run(0, 300);
      rand_run(1, 200);
    join
    check("rand_acc_vs_resp", 0, 32'(dok_n[0]), 32'(acc_n[0]));
    check("rand_acc_vs_resp", 1, 32'(dok_n[1]), 32'(acc_n[1]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
